// File: rtl/foc_pkg.sv
// foc_pkg: shared FOC defaults, coefficient width, ROM value generator and saturation helper
package foc_pkg;

    localparam int ANGLE_BITS = 10;
    localparam int Q_BITS     = 10;

    function automatic int coef_w(int q_bits);
        return q_bits + 2;
    endfunction

    // Elaboration-time only: round(sin(2*pi*k/2**angle_bits) * 2**q_bits) via a Taylor series.
    // Only used for k in the first quadrant, where the series converges fast.
    function automatic int sin_code(int k, int q_bits, int angle_bits);
        real x, term, acc;
        x    = 6.283185307179586 * k / (2.0 ** angle_bits);
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
            acc  = acc + term;
        end
        return $rtoi(acc * (2.0 ** q_bits) + 0.5);
    endfunction

    // Clamp a signed value into the range of a signed width-bit number.
    function automatic logic signed [63:0] sat_trunc(logic signed [63:0] value, int width);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction

endpackage

// File: rtl/park_sincos_lut.sv
// park_sincos_lut: registered sin/cos lookup built from a quarter-wave ROM (pipeline stage S1)
//   clk, rst_n     clock, asynchronous active-low reset
//   en             load new coefficients; outputs hold otherwise
//   theta          unsigned angle, 2**ANGLE_BITS steps per turn
//   sin_o, cos_o   signed coefficients, 1.0 = 2**Q_BITS, valid 1 cycle after en
module park_sincos_lut
    import foc_pkg::*;
#(
    parameter int ANGLE_BITS = foc_pkg::ANGLE_BITS,
    parameter int Q_BITS     = foc_pkg::Q_BITS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [ANGLE_BITS-1:0]             theta,
    output logic signed [coef_w(Q_BITS)-1:0]  sin_o,
    output logic signed [coef_w(Q_BITS)-1:0]  cos_o
);

    localparam int CW = coef_w(Q_BITS);
    localparam int QN = 2 ** (ANGLE_BITS - 2);
    localparam int IW = ANGLE_BITS - 1;

    // Entries 0..QN inclusive so that the exact 90-degree value is stored.
    logic signed [CW-1:0] rom [QN+1];

    for (genvar i = 0; i <= QN; i++) begin : g_rom
        localparam int V = sin_code(i, Q_BITS, ANGLE_BITS);
        assign rom[i] = CW'(V);
    end

    logic [ANGLE_BITS-1:0] th_c;
    logic [IW-1:0]         idx_s, idx_c;
    logic signed [CW-1:0]  sin_d, cos_d, sin_q, cos_q;

    // Odd quadrants read the ROM mirrored, the upper half negates; cos is sin a quarter turn ahead.
    always_comb begin
        th_c  = theta + ANGLE_BITS'(QN);
        idx_s = theta[ANGLE_BITS-2] ? IW'(QN) - {1'b0, theta[ANGLE_BITS-3:0]} : {1'b0, theta[ANGLE_BITS-3:0]};
        idx_c = th_c[ANGLE_BITS-2]  ? IW'(QN) - {1'b0, th_c[ANGLE_BITS-3:0]}  : {1'b0, th_c[ANGLE_BITS-3:0]};
        sin_d = en ? (theta[ANGLE_BITS-1] ? -rom[idx_s] : rom[idx_s]) : sin_q;
        cos_d = en ? (th_c[ANGLE_BITS-1]  ? -rom[idx_c] : rom[idx_c]) : cos_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin_o = sin_q;
    assign cos_o = cos_q;

endmodule

// File: rtl/park_pipe.sv
// park_pipe: 3-stage pipelined Park transform (alpha,beta,theta) -> (d,q) with saturation
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake for alpha, beta, theta
//   out_valid/out_ready   output handshake for d, q, sat
//   d = alpha*cos + beta*sin, q = beta*cos - alpha*sin, floor-shifted by Q_BITS, clipped
//   sat                   d or q was clipped for this sample
module park_pipe
    import foc_pkg::*;
#(
    parameter int D_WIDTH    = 32,
    parameter int Q_BITS     = foc_pkg::Q_BITS,
    parameter int ANGLE_BITS = foc_pkg::ANGLE_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [D_WIDTH-1:0]  alpha,
    input  logic signed [D_WIDTH-1:0]  beta,
    input  logic [ANGLE_BITS-1:0]      theta,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [D_WIDTH-1:0]  d,
    output logic signed [D_WIDTH-1:0]  q,
    output logic                       sat
);

    localparam int CW = coef_w(Q_BITS);
    localparam int PW = D_WIDTH + Q_BITS + 2;

    logic                      adv;
    logic                      v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic signed [D_WIDTH-1:0] a1_d, a1_q, b1_d, b1_q;
    logic signed [CW-1:0]      sin_c, cos_c;
    logic signed [PW-1:0]      p_ac_d, p_ac_q, p_bs_d, p_bs_q, p_bc_d, p_bc_q, p_as_d, p_as_q;
    logic signed [PW-1:0]      d_sum, q_sum;
    logic signed [63:0]        d_sh, q_sh, d_sat, q_sat;
    logic signed [D_WIDTH-1:0] d_out_d, d_out_q, q_out_d, q_out_q;
    logic                      sat_d, sat_q;

    park_sincos_lut #(.ANGLE_BITS(ANGLE_BITS), .Q_BITS(Q_BITS)) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv && in_valid),
        .theta (theta),
        .sin_o (sin_c),
        .cos_o (cos_c)
    );

    // Global stall: every stage moves only when the output register is free or being drained.
    // Data registers load only behind a valid bit, so bubbles never disturb held values.
    always_comb begin
        adv     = !v3_q || out_ready;
        v1_d    = adv ? in_valid : v1_q;
        v2_d    = adv ? v1_q : v2_q;
        v3_d    = adv ? v2_q : v3_q;
        a1_d    = adv && in_valid ? alpha : a1_q;
        b1_d    = adv && in_valid ? beta : b1_q;
        p_ac_d  = adv && v1_q ? PW'(a1_q) * PW'(cos_c) : p_ac_q;
        p_bs_d  = adv && v1_q ? PW'(b1_q) * PW'(sin_c) : p_bs_q;
        p_bc_d  = adv && v1_q ? PW'(b1_q) * PW'(cos_c) : p_bc_q;
        p_as_d  = adv && v1_q ? PW'(a1_q) * PW'(sin_c) : p_as_q;
        d_sum   = p_ac_q + p_bs_q;
        q_sum   = p_bc_q - p_as_q;
        d_sh    = 64'(d_sum >>> Q_BITS);
        q_sh    = 64'(q_sum >>> Q_BITS);
        d_sat   = sat_trunc(d_sh, D_WIDTH);
        q_sat   = sat_trunc(q_sh, D_WIDTH);
        d_out_d = adv && v2_q ? D_WIDTH'(d_sat) : d_out_q;
        q_out_d = adv && v2_q ? D_WIDTH'(q_sat) : q_out_q;
        sat_d   = adv && v2_q ? (d_sat != d_sh) || (q_sat != q_sh) : sat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            p_ac_q  <= '0;
            p_bs_q  <= '0;
            p_bc_q  <= '0;
            p_as_q  <= '0;
            d_out_q <= '0;
            q_out_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            p_ac_q  <= p_ac_d;
            p_bs_q  <= p_bs_d;
            p_bc_q  <= p_bc_d;
            p_as_q  <= p_as_d;
            d_out_q <= d_out_d;
            q_out_q <= q_out_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign d         = d_out_q;
    assign q         = q_out_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_park_pipe.sv
// tb_park_pipe: directed table, stall/stream, wrap, reset and randomized checks for park_pipe
module tb_park_pipe;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 in_ready, out_valid, sat;
    logic signed [DW-1:0] alpha = '0, beta = '0, d, q;
    logic [9:0]           theta = '0;

    int checks = 0, errors = 0, n_out = 0;
    bit done = 1'b0;

    typedef struct {int d; int q; int sat;} res_t;
    typedef struct {int theta; int alpha; int beta; int d; int q; int sat;} vec_t;

    res_t                 exp_q[$];
    bit                   stall_prev = 1'b0;
    logic signed [DW-1:0] d_prev, q_prev;

    park_pipe #(.D_WIDTH(DW), .Q_BITS(10), .ANGLE_BITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alpha     (alpha),
        .beta      (beta),
        .theta     (theta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .q         (q),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic longint clamp(longint v);
        return v > 32767 ? 64'sd32767 : (v < -32768 ? -64'sd32768 : v);
    endfunction

    // Reference: exact trig rounded to Q10, wide integer math, floor shift, clip.
    function automatic res_t model(int th, int a, int b);
        real    ang = 2.0 * 3.141592653589793 * th / 1024.0;
        longint s   = longint'(rnd($sin(ang) * 1024.0));
        longint c   = longint'(rnd($cos(ang) * 1024.0));
        longint dd  = (longint'(a) * c + longint'(b) * s) >>> 10;
        longint qq  = (longint'(b) * c - longint'(a) * s) >>> 10;
        res_t   r;
        r.d   = int'(clamp(dd));
        r.q   = int'(clamp(qq));
        r.sat = (clamp(dd) != dd || clamp(qq) != qq) ? 1 : 0;
        return r;
    endfunction

    function automatic int pick();
        int k = int'($urandom_range(0, 5));
        return k == 0 ? 32767 : (k == 1 ? -32768 : int'($urandom_range(0, 65535)) - 32768);
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(int'(theta), int'(alpha), int'(beta)));
            check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            if (stall_prev) begin
                check("hold_d", int'(d), int'(d_prev));
                check("hold_q", int'(q), int'(q_prev));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got d=%0d q=%0d, expected no output", d, q);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_d", int'(d), e.d);
                    check("sb_q", int'(q), e.q);
                    check("sb_sat", int'(sat), e.sat);
                end
            end
            stall_prev = out_valid && !out_ready;
            d_prev = d;
            q_prev = q;
        end
    end

    // Called shortly after a rising edge; returns shortly after the accepting edge.
    task automatic send(int th, int a, int b);
        int   g = 0;
        logic acc;
        theta    = 10'(th);
        alpha    = 16'(a);
        beta     = 16'(b);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        in_valid = 1'b0;
        check("send_accepted", int'(acc), 1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_in_time", int'(g < 200), 1);
    endtask

    initial begin
        vec_t tbl[10];
        int   lat, n0;
        tbl[0] = '{0,    1000,   500,    1000,   500,   0};
        tbl[1] = '{256,  1000,   500,    500,    -1000, 0};
        tbl[2] = '{512,  1000,   500,    -1000,  -500,  0};
        tbl[3] = '{768,  1000,   500,    -500,   1000,  0};
        tbl[4] = '{128,  32767,  32767,  32767,  0,     1};
        tbl[5] = '{128,  -32768, -32768, -32768, 0,     1};
        tbl[6] = '{1023, 1000,   0,      1000,   5,     0};
        tbl[7] = '{0,    1000,   0,      1000,   0,     0};
        tbl[8] = '{128,  1,      0,      0,      -1,    0};
        tbl[9] = '{64,   0,      0,      0,      0,     0};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_d", int'(d), 0);
        check("reset_q", int'(q), 0);
        check("reset_sat", int'(sat), 0);
        rst_n = 1'b1;
        #1 check("reset_in_ready", int'(in_ready), 1);

        foreach (tbl[i]) begin
            send(tbl[i].theta, tbl[i].alpha, tbl[i].beta);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 10);
            check($sformatf("tbl%0d_latency", i), lat, 3);
            check($sformatf("tbl%0d_d", i), int'(d), tbl[i].d);
            check($sformatf("tbl%0d_q", i), int'(q), tbl[i].q);
            check($sformatf("tbl%0d_sat", i), int'(sat), tbl[i].sat);
            @(posedge clk);
            #1;
        end

        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(k * 100 + 7, 1000 + k * 37, -500 + k * 11);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stream_count", n_out - n0, 8);

        n0 = n_out;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(int'($urandom_range(0, 1023)), pick(), pick());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 2) != 0;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("random_count", n_out - n0, 300);

        send(64, 20000, -12000);
        wait_drain();
        send(0, 1000, 500);
        send(256, 1000, 500);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_d", int'(d), 0);
        check("midrst_q", int'(q), 0);
        check("midrst_sat", int'(sat), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n0 = n_out;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_no_output", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(512, 1000, 500);
        wait_drain();
        check("post_rst_count", n_out - n0, 1);
        check("post_rst_d", int'(d), -1000);
        check("post_rst_q", int'(q), -500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
